// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Default bus widths, owner encoding and grant select type.
package cpu16_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the data-memory arbiter.
// The slave side is the arbiter; the master side is its environment.
interface dmem_arbiter_if
    import cpu16_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   conflict_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive cycles the DMA requester is refused and raises
// dma_prio once it has waited MAX_WAIT cycles in a row.
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic dma_prio
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign dma_prio = (wait_cnt == WAIT_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (!dma_req || dma_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority with a bounded DMA wait,
// one-cycle read return steered to the owner of the pending read.
module dmem_arbiter
    import cpu16_pkg::*;
#(
    parameter int ADDR_W   = cpu16_pkg::ADDR_W,
    parameter int DATA_W   = cpu16_pkg::DATA_W,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    gnt_sel_e    sel;
    logic        dma_prio;
    logic        take_cpu;
    logic        take_dma;
    logic        rd_pend;
    logic        rd_own;
    logic        nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    logic [15:0] conflict_cnt;

    // Conditions are made disjoint so the one-hot decode below holds.
    assign take_dma = reset & bus.dma_req
                    & (dma_prio | ~bus.cpu_req);
    assign take_cpu = reset & bus.cpu_req
                    & ~(dma_prio & bus.dma_req);

    always_comb begin
        sel = GNT_NONE;
        unique case (1'b1)
            take_dma: sel = GNT_DMA;
            take_cpu: sel = GNT_CPU;
            default:  sel = GNT_NONE;
        endcase
    end

    always_comb begin
        nxt_we    = 1'b0;
        nxt_addr  = '0;
        nxt_wdata = '0;
        unique case (sel)
            GNT_CPU: begin
                nxt_we    = bus.cpu_we;
                nxt_addr  = bus.cpu_addr;
                nxt_wdata = bus.cpu_wdata;
            end
            GNT_DMA: begin
                nxt_we    = bus.dma_we;
                nxt_addr  = bus.dma_addr;
                nxt_wdata = bus.dma_wdata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt   = (sel == GNT_CPU);
    assign bus.dma_gnt   = (sel == GNT_DMA);
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_gnt;
    assign bus.mem_en    = (sel != GNT_NONE);
    assign bus.mem_we    = nxt_we;
    assign bus.mem_addr  = nxt_addr;
    assign bus.mem_wdata = nxt_wdata;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .dma_req  (bus.dma_req),
        .dma_gnt  (bus.dma_gnt),
        .dma_prio (dma_prio)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rd_own  <= OWN_CPU;
        end else begin
            rd_pend <= bus.mem_en & ~bus.mem_we;
            rd_own  <= bus.dma_gnt ? OWN_DMA : OWN_CPU;
        end
    end

    assign bus.cpu_rvalid = rd_pend & (rd_own == OWN_CPU);
    assign bus.dma_rvalid = rd_pend & (rd_own == OWN_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= 16'd0;
        end else if (bus.cpu_req && bus.dma_req
                     && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign bus.conflict_cnt = conflict_cnt;

endmodule
